// File: rtl/mem_byte_sequencer_if.sv
// Bundle of the core-side load/store request and the byte-wide memory port.
// The sequencer attaches through the slave modport; the core/memory side uses master.
interface mem_byte_sequencer_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_write;
   logic [1:0]            byte_sel;
   logic                  mem_extend;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  stall;
   logic                  done;
   logic                  misaligned;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [7:0]            mem_wdata;
   logic [7:0]            mem_rdata;
   logic                  mem_ack;

   modport slave (
      input  req_valid, req_write, byte_sel, mem_extend, addr, wdata, mem_rdata, mem_ack,
      output stall, done, misaligned, rdata, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_write, byte_sel, mem_extend, addr, wdata, mem_rdata, mem_ack,
      input  stall, done, misaligned, rdata, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_byte_sequencer.sv
// Splits a byte/halfword/word load or store into single-byte memory transactions,
// assembles and extends load data, and stalls the core until the access completes.
module mem_byte_sequencer #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input logic                 clk,
   input logic                 rst_n,
   mem_byte_sequencer_if.slave bus
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StXfer = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic [1:0] SelHalf = 2'b01;
   localparam logic [1:0] SelByte = 2'b10;

   logic [1:0]            state_q, state_d;
   logic                  write_q, write_d;
   logic                  extend_q, extend_d;
   logic [1:0]            last_q, last_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [1:0]            k_q, k_d;
   logic [DATA_WIDTH-1:0] asm_q, asm_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  sel_half;
   logic                  sel_byte;
   logic [1:0]            req_last;
   logic                  req_misaligned;

   // last_q holds the index of the final byte: 0 = byte, 1 = halfword, 3 = word.
   function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [1:0]            last,
                                                         input logic                  sx,
                                                         input logic [DATA_WIDTH-1:0] a);
      logic [DATA_WIDTH-1:0] r;
      case (last)
         2'd0:    r = {{(DATA_WIDTH-8){sx & a[7]}}, a[7:0]};
         2'd1:    r = {{(DATA_WIDTH-16){sx & a[15]}}, a[15:0]};
         default: r = a;
      endcase
      return r;
   endfunction

   // byte_sel 11 decodes as a word access.
   assign sel_half       = (bus.byte_sel == SelHalf);
   assign sel_byte       = (bus.byte_sel == SelByte);
   assign req_last       = sel_byte ? 2'd0 : (sel_half ? 2'd1 : 2'd3);
   assign req_misaligned = sel_half ? bus.addr[0] : (!sel_byte && (bus.addr[1:0] != 2'b00));

   always_comb begin
      state_d  = state_q;
      write_d  = write_q;
      extend_d = extend_q;
      last_d   = last_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      k_d      = k_q;
      asm_d    = asm_q;
      err_d    = err_q;
      rdata_d  = rdata_q;

      case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               write_d  = bus.req_write;
               extend_d = bus.mem_extend;
               last_d   = req_last;
               addr_d   = bus.addr;
               wdata_d  = bus.wdata;
               k_d      = 2'd0;
               asm_d    = '0;
               err_d    = req_misaligned;
               if (req_misaligned) begin
                  rdata_d = '0;
                  state_d = StDone;
               end else begin
                  state_d = StXfer;
               end
            end
         end
         StXfer: begin
            if (bus.mem_ack) begin
               if (!write_q) begin
                  asm_d[{k_q, 3'b000} +: 8] = bus.mem_rdata;
               end
               if (k_q == last_q) begin
                  // Result is registered here so it stays put until the next access ends.
                  rdata_d = write_q ? '0 : extend_load(last_q, extend_q, asm_d);
                  state_d = StDone;
               end else begin
                  k_d = k_q + 2'd1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         write_q  <= 1'b0;
         extend_q <= 1'b0;
         last_q   <= 2'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         k_q      <= 2'd0;
         asm_q    <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         extend_q <= extend_d;
         last_q   <= last_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         k_q      <= k_d;
         asm_q    <= asm_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   assign bus.stall      = rst_n && (((state_q == StIdle) && bus.req_valid) ||
                                     (state_q == StXfer));
   assign bus.done       = (state_q == StDone);
   assign bus.misaligned = (state_q == StDone) && err_q;
   assign bus.rdata      = rdata_q;
   assign bus.mem_req    = (state_q == StXfer);
   assign bus.mem_we     = (state_q == StXfer) && write_q;
   assign bus.mem_addr   = addr_q + ADDR_WIDTH'(k_q);
   assign bus.mem_wdata  = wdata_q[{k_q, 3'b000} +: 8];

   a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.mem_req && !bus.mem_ack) |=> (bus.mem_req && $stable(bus.mem_addr) &&
                                         $stable(bus.mem_we) && $stable(bus.mem_wdata)));

   a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
      bus.done |=> !bus.done);

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed bench for mem_byte_sequencer: a byte memory responder with programmable
// ack delay and one task per scenario with hand-computed expectations.
module tb_mem_byte_sequencer;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_bad;
   int   wait_cfg;
   int   wait_cnt;
   logic [7:0] mem_img [0:1023];

   int          obs_done_cycle;
   logic [31:0] obs_rdata;
   logic        obs_misal;
   logic        obs_req_in_done;
   int          obs_req_cycles;
   int          obs_ntx;
   logic [63:0] obs_stall_mask;
   logic [31:0] obs_tx_addr  [4];
   logic        obs_tx_we    [4];
   logic [7:0]  obs_tx_wdata [4];

   mem_byte_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   mem_byte_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory responder: ack after wait_cfg idle cycles of a pending request.
   always_comb begin
      bus.mem_ack   = bus.mem_req && (wait_cnt >= wait_cfg);
      bus.mem_rdata = bus.mem_req ? mem_img[bus.mem_addr[9:0]] : 8'h00;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wait_cnt <= 0;
      else if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   // Issues one request at posedge+1 (IDLE assumed) and records what happens until done.
   task automatic run_access(input logic wr, input logic [1:0] sel, input logic ext,
                             input logic [31:0] a, input logic [31:0] wd, input int waits,
                             input bit keep);
      bit seen;
      bus.req_write  = wr;
      bus.byte_sel   = sel;
      bus.mem_extend = ext;
      bus.addr       = a;
      bus.wdata      = wd;
      wait_cfg       = waits;
      bus.req_valid  = 1'b1;
      obs_done_cycle  = -1;
      obs_rdata       = 32'hxxxx_xxxx;
      obs_misal       = 1'bx;
      obs_req_in_done = 1'b0;
      obs_req_cycles  = 0;
      obs_ntx         = 0;
      obs_stall_mask  = '0;
      seen = 1'b0;
      for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
         @(negedge clk);
         if (bus.stall) obs_stall_mask[cyc] = 1'b1;
         if (bus.mem_req) obs_req_cycles++;
         if (bus.mem_req && bus.mem_ack) begin
            if (obs_ntx < 4) begin
               obs_tx_addr[obs_ntx]  = bus.mem_addr;
               obs_tx_we[obs_ntx]    = bus.mem_we;
               obs_tx_wdata[obs_ntx] = bus.mem_wdata;
            end
            obs_ntx++;
         end
         if (bus.done) begin
            seen            = 1'b1;
            obs_done_cycle  = cyc;
            obs_rdata       = bus.rdata;
            obs_misal       = bus.misaligned;
            obs_req_in_done = bus.mem_req;
         end
         @(posedge clk);
         #1;
      end
      if (!keep) bus.req_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (bus.stall !== 1'b0) begin
         n_bad++; $display("FAIL reset_stall: got %b want 0", bus.stall);
      end
      n_checks++;
      if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
         n_bad++; $display("FAIL reset_mem_req_we: got %b%b want 00", bus.mem_req, bus.mem_we);
      end
      n_checks++;
      if (bus.done !== 1'b0 || bus.misaligned !== 1'b0) begin
         n_bad++; $display("FAIL reset_done_mis: got %b%b want 00", bus.done, bus.misaligned);
      end
      n_checks++;
      if (bus.rdata !== 32'h0) begin
         n_bad++; $display("FAIL reset_rdata: got %h want 00000000", bus.rdata);
      end
      n_checks++;
      if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 8'h0) begin
         n_bad++; $display("FAIL reset_mem_addr_wdata: got %h/%h want 0/0",
                           bus.mem_addr, bus.mem_wdata);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_lb_signed();
      mem_img[10'h100] = 8'h80;
      run_access(1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 0, 1'b0);
      n_checks++;
      if (obs_done_cycle !== 2) begin
         n_bad++; $display("FAIL lb_done_cycle: got %0d want 2", obs_done_cycle);
      end
      n_checks++;
      if (obs_ntx !== 1 || obs_tx_addr[0] !== 32'h100 || obs_tx_we[0] !== 1'b0) begin
         n_bad++; $display("FAIL lb_txn: got n=%0d addr=%h we=%b want n=1 addr=00000100 we=0",
                           obs_ntx, obs_tx_addr[0], obs_tx_we[0]);
      end
      n_checks++;
      if (obs_rdata !== 32'hFFFF_FF80 || obs_misal !== 1'b0) begin
         n_bad++; $display("FAIL lb_rdata: got %h mis=%b want ffffff80 mis=0",
                           obs_rdata, obs_misal);
      end
      n_checks++;
      if (obs_stall_mask[2:0] !== 3'b011) begin
         n_bad++; $display("FAIL lb_stall: got %b want 011", obs_stall_mask[2:0]);
      end
      @(negedge clk);
      n_checks++;
      if (bus.rdata !== 32'hFFFF_FF80 || bus.stall !== 1'b0) begin
         n_bad++; $display("FAIL lb_rdata_hold: got %h stall=%b want ffffff80 stall=0",
                           bus.rdata, bus.stall);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_lhu_wait();
      mem_img[10'h202] = 8'h34;
      mem_img[10'h203] = 8'h92;
      run_access(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 2, 1'b0);
      n_checks++;
      if (obs_done_cycle !== 7) begin
         n_bad++; $display("FAIL lhu_done_cycle: got %0d want 7", obs_done_cycle);
      end
      n_checks++;
      if (obs_ntx !== 2 || obs_tx_addr[0] !== 32'h202 || obs_tx_addr[1] !== 32'h203) begin
         n_bad++; $display("FAIL lhu_txn: got n=%0d %h %h want n=2 00000202 00000203",
                           obs_ntx, obs_tx_addr[0], obs_tx_addr[1]);
      end
      n_checks++;
      if (obs_req_cycles !== 6) begin
         n_bad++; $display("FAIL lhu_req_cycles: got %0d want 6", obs_req_cycles);
      end
      n_checks++;
      if (obs_rdata !== 32'h0000_9234) begin
         n_bad++; $display("FAIL lhu_rdata: got %h want 00009234", obs_rdata);
      end
      n_checks++;
      if (obs_stall_mask[7:0] !== 8'h7F) begin
         n_bad++; $display("FAIL lhu_stall: got %b want 01111111", obs_stall_mask[7:0]);
      end
   endtask

   task automatic test_extend();
      mem_img[10'h600] = 8'h01;
      mem_img[10'h601] = 8'h80;
      mem_img[10'h610] = 8'h80;
      run_access(1'b0, 2'b01, 1'b1, 32'h600, 32'h0, 0, 1'b0);
      n_checks++;
      if (obs_rdata !== 32'hFFFF_8001 || obs_done_cycle !== 3) begin
         n_bad++; $display("FAIL lh_signed: got %h @%0d want ffff8001 @3",
                           obs_rdata, obs_done_cycle);
      end
      run_access(1'b0, 2'b10, 1'b0, 32'h610, 32'h0, 1, 1'b0);
      n_checks++;
      if (obs_rdata !== 32'h0000_0080 || obs_done_cycle !== 3) begin
         n_bad++; $display("FAIL lbu_zero: got %h @%0d want 00000080 @3",
                           obs_rdata, obs_done_cycle);
      end
      mem_img[10'h620] = 8'h11;
      mem_img[10'h621] = 8'h22;
      mem_img[10'h622] = 8'h33;
      mem_img[10'h623] = 8'hC4;
      run_access(1'b0, 2'b00, 1'b1, 32'h620, 32'h0, 0, 1'b0);
      n_checks++;
      if (obs_rdata !== 32'hC433_2211 || obs_done_cycle !== 5) begin
         n_bad++; $display("FAIL lw_word: got %h @%0d want c4332211 @5",
                           obs_rdata, obs_done_cycle);
      end
   endtask

   task automatic test_sw();
      logic [7:0] exp_b [4];
      exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
      run_access(1'b1, 2'b00, 1'b0, 32'h300, 32'hDEAD_BEEF, 0, 1'b0);
      n_checks++;
      if (obs_done_cycle !== 5 || obs_ntx !== 4) begin
         n_bad++; $display("FAIL sw_done: got cycle %0d n=%0d want cycle 5 n=4",
                           obs_done_cycle, obs_ntx);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (obs_tx_addr[i] !== 32'h300 + 32'(i) || obs_tx_we[i] !== 1'b1 ||
             obs_tx_wdata[i] !== exp_b[i]) begin
            n_bad++; $display("FAIL sw_byte%0d: got %h we=%b d=%h want %h we=1 d=%h", i,
                              obs_tx_addr[i], obs_tx_we[i], obs_tx_wdata[i],
                              32'h300 + 32'(i), exp_b[i]);
         end
      end
      n_checks++;
      if (obs_rdata !== 32'h0) begin
         n_bad++; $display("FAIL sw_rdata: got %h want 00000000", obs_rdata);
      end
   endtask

   task automatic test_misaligned();
      mem_img[10'h303] = 8'h5A;
      run_access(1'b0, 2'b10, 1'b0, 32'h303, 32'h0, 0, 1'b0);
      n_checks++;
      if (obs_misal !== 1'b0 || obs_rdata !== 32'h0000_005A || obs_done_cycle !== 2) begin
         n_bad++; $display("FAIL lb_odd: got mis=%b %h @%0d want mis=0 0000005a @2",
                           obs_misal, obs_rdata, obs_done_cycle);
      end
      run_access(1'b0, 2'b00, 1'b0, 32'h302, 32'h0, 0, 1'b0);
      n_checks++;
      if (obs_misal !== 1'b1 || obs_done_cycle !== 1 || obs_rdata !== 32'h0 ||
          obs_req_cycles !== 0) begin
         n_bad++; $display("FAIL lw_mis: got mis=%b @%0d %h req=%0d want mis=1 @1 0 req=0",
                           obs_misal, obs_done_cycle, obs_rdata, obs_req_cycles);
      end
      run_access(1'b1, 2'b01, 1'b0, 32'h301, 32'h1234, 0, 1'b0);
      n_checks++;
      if (obs_misal !== 1'b1 || obs_done_cycle !== 1 || obs_rdata !== 32'h0 ||
          obs_req_cycles !== 0) begin
         n_bad++; $display("FAIL sh_mis: got mis=%b @%0d %h req=%0d want mis=1 @1 0 req=0",
                           obs_misal, obs_done_cycle, obs_rdata, obs_req_cycles);
      end
      run_access(1'b0, 2'b11, 1'b0, 32'h302, 32'h0, 0, 1'b0);
      n_checks++;
      if (obs_misal !== 1'b1 || obs_done_cycle !== 1) begin
         n_bad++; $display("FAIL sel11_mis: got mis=%b @%0d want mis=1 @1",
                           obs_misal, obs_done_cycle);
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      bit any_done;
      mem_img[10'h100] = 8'h80;
      bus.req_write  = 1'b0;
      bus.byte_sel   = 2'b00;
      bus.mem_extend = 1'b0;
      bus.addr       = 32'h400;
      bus.wdata      = 32'h0;
      wait_cfg       = 3;
      bus.req_valid  = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (bus.mem_req && bus.mem_addr == 32'h401) found = 1'b1;
      end
      n_checks++;
      if (found !== 1'b1) begin
         n_bad++; $display("FAIL rstmid_reach_k1: got %b want 1", found);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0 || bus.done !== 1'b0) begin
         n_bad++; $display("FAIL rstmid_abort: got req=%b stall=%b done=%b want 0 0 0",
                           bus.mem_req, bus.stall, bus.done);
      end
      any_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.done || bus.mem_req) any_done = 1'b1;
      end
      bus.req_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      if (bus.done || bus.mem_req) any_done = 1'b1;
      n_checks++;
      if (any_done !== 1'b0) begin
         n_bad++; $display("FAIL rstmid_no_done: got %b want 0", any_done);
      end
      @(posedge clk);
      #1;
      run_access(1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 0, 1'b0);
      n_checks++;
      if (obs_done_cycle !== 2 || obs_rdata !== 32'hFFFF_FF80) begin
         n_bad++; $display("FAIL rstmid_after_lb: got %h @%0d want ffffff80 @2",
                           obs_rdata, obs_done_cycle);
      end
   endtask

   task automatic test_back_to_back();
      mem_img[10'h501] = 8'h7F;
      run_access(1'b1, 2'b10, 1'b0, 32'h500, 32'h0000_00A5, 0, 1'b1);
      n_checks++;
      if (obs_done_cycle !== 2 || obs_ntx !== 1 || obs_tx_addr[0] !== 32'h500 ||
          obs_tx_we[0] !== 1'b1 || obs_tx_wdata[0] !== 8'hA5) begin
         n_bad++; $display("FAIL b2b_sb: got @%0d n=%0d %h we=%b d=%h want @2 n=1 500 1 a5",
                           obs_done_cycle, obs_ntx, obs_tx_addr[0], obs_tx_we[0],
                           obs_tx_wdata[0]);
      end
      n_checks++;
      if (obs_req_in_done !== 1'b0) begin
         n_bad++; $display("FAIL b2b_sb_req_in_done: got %b want 0", obs_req_in_done);
      end
      run_access(1'b0, 2'b10, 1'b1, 32'h501, 32'h0, 0, 1'b0);
      n_checks++;
      if (obs_done_cycle !== 2 || obs_stall_mask[0] !== 1'b1) begin
         n_bad++; $display("FAIL b2b_lb_accept: got @%0d stall0=%b want @2 stall0=1",
                           obs_done_cycle, obs_stall_mask[0]);
      end
      n_checks++;
      if (obs_rdata !== 32'h0000_007F || obs_req_in_done !== 1'b0) begin
         n_bad++; $display("FAIL b2b_lb_rdata: got %h req_in_done=%b want 0000007f 0",
                           obs_rdata, obs_req_in_done);
      end
   endtask

   initial begin
      n_checks = 0;
      n_bad    = 0;
      wait_cfg = 0;
      for (int i = 0; i < 1024; i++) mem_img[i] = 8'h00;
      rst_n          = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.byte_sel   = 2'b00;
      bus.mem_extend = 1'b0;
      bus.addr       = 32'h302;
      bus.wdata      = 32'h0;
      test_reset();
      test_lb_signed();
      test_lhu_wait();
      test_extend();
      test_sw();
      test_misaligned();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
